// File: rtl/shift_deser.sv
// shift_deser: LSB-first serial-to-parallel deserializer with a valid/ready output register.
// Optional even-parity bit per word when SHIFT_DESER_PARITY_EN is defined.
module shift_deser #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             s_clear,
   input  logic             s_valid,
   input  logic             s_in,
   output logic [WIDTH-1:0] d_out,
   output logic             d_valid,
   input  logic             d_ready,
   output logic             busy,
   output logic             overrun,
   output logic             parity_err
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef SHIFT_DESER_PARITY_EN
   typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
`else
   typedef enum logic {IDLE, DATA} state_t;
`endif
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sr_q, sr_d, d_out_q, word;
   logic d_valid_q, ovr_q, done;
`ifdef SHIFT_DESER_PARITY_EN
   logic par_q, perr;
`endif
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      sr_d = sr_q;
      word = sr_q;
      done = 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
      perr = 1'b0;
`endif
      if (s_clear) begin
         state_d = IDLE;
         cnt_d = '0;
         sr_d = '0;
      end
`ifdef SHIFT_DESER_PARITY_EN
      else if (s_valid && state_q == PARITY) begin
         state_d = IDLE;
         done = 1'b1;
         perr = ^{sr_q, s_in};
      end
`endif
      else if (s_valid) begin
         sr_d = {s_in, sr_q[WIDTH-1:1]};
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
`ifdef SHIFT_DESER_PARITY_EN
         state_d = (cnt_q == LAST) ? PARITY : DATA;
`else
         state_d = (cnt_q == LAST) ? IDLE : DATA;
         done = (cnt_q == LAST);
         word = sr_d;
`endif
      end
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q <= '0;
         sr_q <= '0;
         d_out_q <= '0;
         d_valid_q <= 1'b0;
         ovr_q <= 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
         par_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         sr_q <= sr_d;
         // A completing word is accepted only if the output slot is empty or being drained now.
         if (done && (!d_valid_q || d_ready)) begin
            d_out_q <= word;
            d_valid_q <= 1'b1;
`ifdef SHIFT_DESER_PARITY_EN
            par_q <= perr;
`endif
         end else if (done)
            ovr_q <= 1'b1;
         else if (d_valid_q && d_ready)
            d_valid_q <= 1'b0;
      end
   end
   assign d_out = d_out_q;
   assign d_valid = d_valid_q;
   assign overrun = ovr_q;
   assign busy = (state_q != IDLE);
`ifdef SHIFT_DESER_PARITY_EN
   assign parity_err = par_q;
`else
   logic unused_sr0;
   assign unused_sr0 = sr_q[0];
   assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_shift_deser.sv
// tb_shift_deser: directed checks of shift_deser with immediate assertions.
module tb_shift_deser;
   localparam int WIDTH = 8;
`ifdef SHIFT_DESER_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   logic clock = 1'b0, reset = 1'b0, s_clear = 1'b0, s_valid = 1'b0, s_in = 1'b0, d_ready = 1'b0;
   logic [WIDTH-1:0] d_out;
   logic d_valid, busy, overrun, parity_err;
   int checks = 0, errors = 0;

   shift_deser #(.WIDTH(WIDTH)) dut (
      .clock(clock), .reset(reset), .s_clear(s_clear), .s_valid(s_valid), .s_in(s_in),
      .d_out(d_out), .d_valid(d_valid), .d_ready(d_ready), .busy(busy),
      .overrun(overrun), .parity_err(parity_err)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_bit(input logic b);
      s_valid = 1'b1;
      s_in = b;
      tick();
      s_valid = 1'b0;
      s_in = 1'b0;
   endtask

   // Sends a full word (plus correct even parity when enabled); rl raises d_ready for the final edge only.
   task automatic send_word(input logic [WIDTH-1:0] w, input int gap, input bit rl);
      for (int i = 0; i < WIDTH; i++) begin
         if (i > 0) repeat (gap) tick();
         if (rl && !PAR && i == WIDTH - 1) d_ready = 1'b1;
         send_bit(w[i]);
      end
      if (PAR) begin
         if (rl) d_ready = 1'b1;
         send_bit(^w);
      end
      if (rl) d_ready = 1'b0;
   endtask

   task automatic consume();
      d_ready = 1'b1;
      tick();
      d_ready = 1'b0;
   endtask

   initial begin
      logic [WIDTH-1:0] v;
      #2;
      check("rst_dout", d_out, 0);
      check("rst_dvalid", d_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_parity", parity_err, 0);
      tick();
      reset = 1'b1;
      tick();
      // reset mid-word, then a clean 0x55
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
      check("partial_busy", busy, 1);
      reset = 1'b0;
      #1;
      check("async_rst_busy", busy, 0);
      tick();
      reset = 1'b1;
      tick();
      send_word(8'h55, 0, 1'b0);
      check("w55_dout", d_out, 8'h55);
      check("w55_dvalid", d_valid, 1);
      check("w55_busy", busy, 0);
      consume();
      check("w55_consumed", d_valid, 0);
      // gapped bits
      v = 8'hCC;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) repeat (2) tick();
         send_bit(v[i]);
      end
      repeat (2) tick();
      check("gap_busy", busy, 1);
      check("gap_dvalid", d_valid, 0);
      for (int i = 4; i < WIDTH; i++) begin
         repeat (2) tick();
         send_bit(v[i]);
      end
      if (PAR) send_bit(^v);
      check("gap_dout", d_out, 8'hCC);
      check("gap_dvalid2", d_valid, 1);
      consume();
      // completion coinciding with a handshake
      send_word(8'hF0, 0, 1'b0);
      check("f0_dout", d_out, 8'hF0);
      send_word(8'h0F, 0, 1'b1);
      check("hs_dout", d_out, 8'h0F);
      check("hs_dvalid", d_valid, 1);
      check("hs_overrun", overrun, 0);
      consume();
      check("hs_consumed", d_valid, 0);
      // s_clear mid-word, with priority over s_valid
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      s_clear = 1'b1;
      s_valid = 1'b1;
      s_in = 1'b1;
      tick();
      s_clear = 1'b0;
      s_valid = 1'b0;
      check("clr_busy", busy, 0);
      check("clr_dvalid", d_valid, 0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      check("clr_no_early", d_valid, 0);
      for (int i = 4; i < WIDTH; i++) send_bit(1'b1);
      if (PAR) send_bit(1'b0);
      check("clr_dout", d_out, 8'hFF);
      check("clr_dvalid2", d_valid, 1);
      consume();
      // overrun
      send_word(8'hA5, 0, 1'b0);
      check("a5_dout", d_out, 8'hA5);
      send_word(8'h3C, 0, 1'b0);
      check("ovr_dout", d_out, 8'hA5);
      check("ovr_flag", overrun, 1);
      check("ovr_dvalid", d_valid, 1);
      consume();
      check("ovr_sticky", overrun, 1);
      check("ovr_drained", d_valid, 0);
      reset = 1'b0;
      #1;
      check("ovr_rst", overrun, 0);
      check("ovr_rst_dout", d_out, 0);
      tick();
      reset = 1'b1;
      tick();
      // parity status
      v = 8'h55;
      for (int i = 0; i < WIDTH; i++) send_bit(v[i]);
      if (PAR) begin
         check("par_busy", busy, 1);
         check("par_wait", d_valid, 0);
         send_bit(1'b1);
         check("par_err1", parity_err, 1);
         consume();
         for (int i = 0; i < WIDTH; i++) send_bit(v[i]);
         send_bit(1'b0);
         check("par_err0", parity_err, 0);
      end else begin
         check("nopar_err", parity_err, 0);
      end
      check("par_dout", d_out, 8'h55);
      check("par_dvalid", d_valid, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
